pool_stream_clked: RTL
======================

// Module: pool_stream_clked
// PURPOSE
//  Downstream stage of the clocked convolution engine. Consumes the raster-order stream of
//  convolved pixels (one map of mapSize x mapSize, row-major) and performs 2x2 stride-2
//  pooling. Emits the pooled map, also raster-order, on a valid/ready stream.
//  A single line buffer holds the pair-reduced values of each even row.
// PARAMETERS
//  DATA_W   16  signed pixel width, in and out
//  MAX_MAP  32  largest supported input map edge; line buffer depth = MAX_MAP/2
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high
//  start      in   1       pulse; latches mapSize, clears counters, begins a map
//  mapSize    in   16      input map edge (imgSize - filterSize + 1 of conv stage)
//  in_valid   in   1       convolved pixel present
//  in_data    in   DATA_W  convolved pixel, signed
//  in_ready   out  1       pixel accepted when in_valid && in_ready
//  out_valid  out  1       pooled pixel present
//  out_data   out  DATA_W  pooled pixel, signed
//  out_ready  in   1       consumer accepts when out_valid && out_ready
//  done       out  1       sticky: whole map consumed and last output accepted
// BEHAVIOUR
//  - Reset: state IDLE, row=col=0, out_valid=0, out_data=0, done=0, in_ready=0. Line buffer not cleared.
//  - FSM: IDLE -start-> RUN (or DONE if mapSize<2 or mapSize>MAX_MAP, no outputs);
//    RUN -last pixel accepted && out reg empty-> DONE; DONE -start-> RUN. start ignored in RUN.
//  - done=1 only in DONE; cleared the cycle after start is sampled.
//  - in_ready = (state==RUN) && (!out_valid || out_ready). Single output register, no bubble
//    under continuous ready: 1 pooled pixel per 4 inputs at full throughput.
//  - Counters col/row advance per accepted pixel; col wraps at mapSize-1, row increments.
//  - Even col: hold pixel in pair register. Odd col: pair = combine(hold, pixel).
//    Even row: pair written to linebuf[col>>1]. Odd row: out = combine(linebuf[col>>1], pair).
//  - Latency: out_valid rises the cycle after the 4th contributing pixel (odd row, odd col).
//  - Odd mapSize: last column and last row consumed but discarded (floor pooling);
//    output edge = mapSize>>1.
//  - Average arithmetic: pair sums DATA_W+1 bits, quad sum DATA_W+2 bits, result = sum>>>2
//    (arithmetic, rounds toward -inf); never overflows, no saturation.
//  - Input accepted and output popped in the same cycle is legal and lossless.
//  - reset mid-map: abort immediately, return to IDLE, pending output dropped.
// CONFIGURATION
//  POOL_MAX_EN defined: combine = signed max; line buffer width DATA_W; out = max of 4.
//  POOL_MAX_EN undefined: combine = signed sum; out = average as above.
// STRUCTURE
//  - cnn_pkg: DATA_W, MAX_MAP constants; typedef enum {IDLE,RUN,DONE} pool_state_t;
//    typedef logic signed [DATA_W+1:0] pool_acc_t.
//  - Sub-module pool_line_buffer: MAX_MAP/2 x width, 1 write port, 1 async read port, no reset.
//  - Top holds FSM, counters, pair register, output register.
// TESTING
//  1. mapSize=4, inputs 0..15, ready=1 -> outputs 2,4,10,12 (avg); then done=1.
//  2. mapSize=2, inputs -1,-2,-2,-2 -> sum -7 >>>2 -> out -2; done.
//  3. mapSize=5, inputs 0..24 -> 4 outputs 3,5,13,15; row 4 / col 4 discarded; done after 25 accepts.
//  4. mapSize=4, out_ready low 10 cycles after first output -> in_ready low, no loss, same values as 1.
//  5. Reset asserted after 6 accepted pixels -> out_valid=0, done=0, IDLE; next start mapSize=4 gives test-1 results.
//  6. POOL_MAX_EN, mapSize=4, inputs 0..15 -> 5,7,13,15; mapSize=1 start -> done next cycle, no outputs.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants and types for the convolution-engine pooling stage.
package cnn_pkg;

    localparam int DATA_W  = 16;
    localparam int MAX_MAP = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } pool_state_t;

    // Wide enough for the sum of four DATA_W-bit signed pixels.
    typedef logic signed [DATA_W+1:0] pool_acc_t;

endpackage

// File: rtl/pool_line_buffer.sv
// Line buffer for pair-reduced values of an even row.
// One synchronous write port and one asynchronous read port. Contents are not reset.
module pool_line_buffer
    import cnn_pkg::*;
#(
    parameter  int WIDTH = DATA_W + 1,
    parameter  int DEPTH = MAX_MAP / 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store one pair-reduced value per pooled column.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pool_stream_clked.sv
// 2x2 stride-2 pooling over a raster-order stream of convolved pixels.
// Build option: define POOL_MAX_EN for max pooling; default build averages.
module pool_stream_clked
    import cnn_pkg::*;
#(
    parameter int DATA_W  = cnn_pkg::DATA_W,
    parameter int MAX_MAP = cnn_pkg::MAX_MAP
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [15:0]              mapSize,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    input  logic                     out_ready,
    output logic                     done
);

    localparam int AW = $clog2(MAX_MAP / 2);

`ifdef POOL_MAX_EN
    localparam int LB_W = DATA_W;

    function automatic logic signed [LB_W-1:0] combine_pair(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [DATA_W-1:0] combine_quad(
        input logic signed [LB_W-1:0] a,
        input logic signed [LB_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction
`else
    localparam int LB_W = DATA_W + 1;

    function automatic logic signed [LB_W-1:0] combine_pair(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return {a[DATA_W-1], a} + {b[DATA_W-1], b};
    endfunction

    // Quad sum fits in DATA_W+2 bits; arithmetic shift floors toward -inf.
    function automatic logic signed [DATA_W-1:0] combine_quad(
        input logic signed [LB_W-1:0] a,
        input logic signed [LB_W-1:0] b
    );
        logic signed [DATA_W+1:0] s;
        s = {a[LB_W-1], a} + {b[LB_W-1], b};
        return s[DATA_W+1:2];
    endfunction
`endif

    pool_state_t state, state_nxt;

    logic [15:0]              ms;
    logic [15:0]              row;
    logic [15:0]              col;
    logic                     map_end;
    logic signed [DATA_W-1:0] hold_p0;

    logic                     accept;
    logic                     start_take;
    logic                     last_pix;
    logic                     produce;
    logic                     lb_we;
    logic signed [LB_W-1:0]   pair_val;
    logic signed [LB_W-1:0]   lb_rd;
    logic [LB_W-1:0]          lb_rdata;

    assign in_ready   = (state == RUN) && !map_end && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign start_take = start && (state != RUN);
    assign last_pix   = (row == ms - 16'd1) && (col == ms - 16'd1);
    assign produce    = accept && row[0] && col[0];
    assign lb_we      = accept && !row[0] && col[0];
    assign pair_val   = combine_pair(hold_p0, in_data);
    assign lb_rd      = lb_rdata;
    assign done       = (state == DONE);

    pool_line_buffer #(
        .WIDTH (LB_W),
        .DEPTH (MAX_MAP / 2)
    ) u_linebuf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (col[AW:1]),
        .wdata (pair_val),
        .raddr (col[AW:1]),
        .rdata (lb_rdata)
    );

    // Next-state logic: start launches a map, end of map waits for the output register to drain.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    if (mapSize < 16'd2 || mapSize > 16'(MAX_MAP)) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (map_end && !out_valid) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and raster counters; map size is latched on an accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            row     <= '0;
            col     <= '0;
            map_end <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_take) begin
                ms      <= mapSize;
                row     <= '0;
                col     <= '0;
                map_end <= 1'b0;
            end else if (accept) begin
                if (last_pix) begin
                    map_end <= 1'b1;
                end
                if (col == ms - 16'd1) begin
                    col <= '0;
                    row <= row + 16'd1;
                end else begin
                    col <= col + 16'd1;
                end
            end
        end
    end

    // Even-column pixel waits here for its horizontal partner.
    always_ff @(posedge clk) begin
        if (accept && !col[0]) begin
            hold_p0 <= in_data;
        end
    end

    // Output register: loads on the fourth pixel of a window, empties when the consumer takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (produce) begin
            out_valid <= 1'b1;
            out_data  <= combine_quad(lb_rd, pair_val);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
